// File: rtl/key_pad_emulator.sv
// Responder side of a 4x4 active-low row-scan keypad: turns a press request into a timed
// contact sequence (bounce-in, hold, bounce-out, release gap) seen on kp_col.
module key_pad_emulator #(
  parameter int BOUNCE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 20,
  parameter int GAP_CYCLES    = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic       cancel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             contact, contact_nxt;
  logic [3:0]       key, key_nxt;
  logic             done_nxt;
  logic [3:0]       key_rc;

  // Key position as {row index, column index}; index 0 is the LSB strobe/sense line.
  function automatic logic [3:0] key_pos(input logic [3:0] k);
    logic [3:0] rc;
    case (k)
      4'h7: rc = 4'b00_00;
      4'h4: rc = 4'b00_01;
      4'h1: rc = 4'b00_10;
      4'h0: rc = 4'b00_11;
      4'h8: rc = 4'b01_00;
      4'h5: rc = 4'b01_01;
      4'h2: rc = 4'b01_10;
      4'hA: rc = 4'b01_11;
      4'h9: rc = 4'b10_00;
      4'h6: rc = 4'b10_01;
      4'h3: rc = 4'b10_10;
      4'hB: rc = 4'b10_11;
      4'hC: rc = 4'b11_00;
      4'hD: rc = 4'b11_01;
      4'hE: rc = 4'b11_10;
      default: rc = 4'b11_11;
    endcase
    return rc;
  endfunction

  function automatic logic contact_of(input state_t s, input logic [CNT_W-1:0] c);
    logic on;
    case (s)
      BOUNCE_IN:  on = ~c[0];
      HOLD:       on = 1'b1;
      BOUNCE_OUT: on = c[0];
      default:    on = 1'b0;
    endcase
    return on;
  endfunction

  // Next-state: phase sequencing, request accept and cancel
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    key_nxt   = key;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_valid && req_ready) begin
          key_nxt = req_key;
          if (BOUNCE_CYCLES == 0) state_nxt = HOLD;
          else                    state_nxt = BOUNCE_IN;
        end
      end
      BOUNCE_IN: begin
        if (cnt == BOUNCE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          if (BOUNCE_CYCLES == 0) state_nxt = GAP;
          else                    state_nxt = BOUNCE_OUT;
          cnt_nxt = '0;
        end
      end
      BOUNCE_OUT: begin
        if (cnt == BOUNCE_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Cancel overrides any phase change that would happen on the same edge
    if (cancel && (state == BOUNCE_IN || state == HOLD || state == BOUNCE_OUT)) begin
      state_nxt = GAP;
      cnt_nxt   = '0;
    end
    contact_nxt = contact_of(state_nxt, cnt_nxt);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      key     <= 4'h0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      contact <= contact_nxt;
      key     <= key_nxt;
      done    <= done_nxt;
    end
  end

  assign req_ready = rst && (state == IDLE);
  assign busy      = (state != IDLE);
  assign key_rc    = key_pos(key);

  // Column sense follows the row strobe combinationally so the scanner sees it the same cycle
  always_comb begin
    kp_col = 4'b1111;
    if (contact && (kp_row == ~(4'b0001 << key_rc[3:2])))
      kp_col = ~(4'b0001 << key_rc[1:0]);
  end

endmodule

// File: tb/tb_key_pad_emulator.sv
// Bench for key_pad_emulator: a press-timeline model checked every cycle on two instances
// (bouncing and clean-edge), plus directed literal checks of the keypad behaviour.
module tb_key_pad_emulator;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [3:0] kp_row;
  logic       rs[2], rv[2], cn[2];
  logic [3:0] rk[2];
  logic [3:0] col[2];
  logic       rdy[2], bsy[2], dn[2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  key_pad_emulator #(.BOUNCE_CYCLES(2), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rs[0]), .kp_row(kp_row), .kp_col(col[0]), .req_valid(rv[0]),
    .req_key(rk[0]), .req_ready(rdy[0]), .cancel(cn[0]), .busy(bsy[0]), .done(dn[0]));

  key_pad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rs[1]), .kp_row(kp_row), .kp_col(col[1]), .req_valid(rv[1]),
    .req_key(rk[1]), .req_ready(rdy[1]), .cancel(cn[1]), .busy(bsy[1]), .done(dn[1]));

  // Model: a press is a list of per-cycle entries {cancellable, contact}
  int         PB[2] = '{2, 0};
  int         PH    = 4;
  int         PG    = 2;
  int         kmap[4][4] = '{'{7, 4, 1, 0}, '{8, 5, 2, 10}, '{9, 6, 3, 11}, '{12, 13, 14, 15}};
  int         sched[2][64];
  int         slen[2], spos[2];
  bit         m_busy[2], m_contact[2], m_canc[2], m_done[2];
  logic [3:0] m_key[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_contact[i] = 0; m_canc[i] = 0; m_done[i] = 0; m_key[i] = 0;
      slen[i] = 0; spos[i] = 0;
    end
  end

  task automatic take_entry(input int i);
    int e;
    e = sched[i][spos[i]];
    spos[i]++;
    m_contact[i] = (e % 2) == 1;
    m_canc[i]    = e >= 2;
  endtask

  task automatic step(input int i);
    int n;
    if (!rs[i]) begin
      m_busy[i] = 0; m_done[i] = 0; m_key[i] = 0; m_contact[i] = 0; m_canc[i] = 0;
    end else if (m_busy[i]) begin
      m_done[i] = 0;
      if (cn[i] && m_canc[i]) begin
        for (int g = 0; g < PG; g++) sched[i][g] = 0;
        slen[i] = PG;
        spos[i] = 0;
      end
      if (spos[i] >= slen[i]) begin
        m_busy[i] = 0; m_done[i] = 1; m_contact[i] = 0; m_canc[i] = 0;
      end else begin
        take_entry(i);
      end
    end else begin
      m_done[i] = 0;
      if (rv[i]) begin
        m_key[i] = rk[i];
        n = 0;
        for (int b = 0; b < PB[i]; b++) begin sched[i][n] = (b % 2 == 0) ? 3 : 2; n++; end
        for (int h = 0; h < PH; h++)    begin sched[i][n] = 3; n++; end
        for (int b = 0; b < PB[i]; b++) begin sched[i][n] = (b % 2 == 1) ? 3 : 2; n++; end
        for (int g = 0; g < PG; g++)    begin sched[i][n] = 0; n++; end
        slen[i] = n;
        spos[i] = 0;
        m_busy[i] = 1;
        take_entry(i);
      end
    end
  endtask

  function automatic logic [3:0] exp_col(input logic [3:0] key, input bit c, input logic [3:0] row);
    logic [3:0] res, sel;
    res = 4'hF;
    if (c) begin
      for (int r = 0; r < 4; r++) begin
        for (int cc = 0; cc < 4; cc++) begin
          sel = ~(4'b0001 << r);
          if (kmap[r][cc] == int'(key) && row == sel) res = ~(4'b0001 << cc);
        end
      end
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("kp_col[%0d]", i), col[i], exp_col(m_key[i], m_contact[i], kp_row));
        chk($sformatf("req_ready[%0d]", i), rdy[i], rs[i] && !m_busy[i]);
        chk($sformatf("busy[%0d]", i), bsy[i], m_busy[i]);
        chk($sformatf("done[%0d]", i), dn[i], m_done[i]);
      end
    end
  end

  task automatic wait_idle(input int i);
    for (int k = 0; k < 40; k++) begin
      if (!bsy[i]) break;
      @(negedge clk);
    end
    chk("wait_idle", bsy[i], 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int         pat[10] = '{1, 0, 1, 1, 1, 1, 0, 1, 0, 0};
  logic [3:0] rows[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] tab[16] = '{8'hE7, 8'hEB, 8'hDB, 8'hBB, 8'hED, 8'hDD, 8'hBD, 8'hEE,
                          8'hDE, 8'hBE, 8'hD7, 8'hB7, 8'h7E, 8'h7D, 8'h7B, 8'h77};
  logic [3:0] rpat[7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b0000, 4'b1100};

  initial begin
    int cnt;
    logic [7:0] t;
    kp_row = 4'hF;
    for (int i = 0; i < 2; i++) begin rs[i] = 0; rv[i] = 0; cn[i] = 0; rk[i] = 0; end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", rdy[i], 0); chk("rst_busy", bsy[i], 0);
      chk("rst_col", col[i], 4'hF); chk("rst_done", dn[i], 0);
    end
    @(posedge clk); #1;
    rs[0] = 1; rs[1] = 1;
    @(negedge clk);
    chk("ready_after_rst", rdy[0], 1);
    @(posedge clk); #1;

    // Key 8, static row 1101: contact pattern then done
    kp_row = 4'b1101; rk[0] = 4'h8; rv[0] = 1;
    @(posedge clk); #1; rv[0] = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t1_col%0d", k), col[0], (pat[k] == 1) ? 4'hE : 4'hF);
      chk("t1_busy", bsy[0], 1);
    end
    @(negedge clk);
    chk("t1_done", dn[0], 1); chk("t1_idle", bsy[0], 0); chk("t1_ready", rdy[0], 1);
    @(negedge clk);
    chk("t1_done_pulse", dn[0], 0);
    @(posedge clk); #1;

    // Key 8 with the scanner cycling rows
    rk[0] = 4'h8; rv[0] = 1;
    @(posedge clk); #1; rv[0] = 0;
    for (int c = 0; c < 14; c++) begin
      kp_row = rows[c % 4];
      @(negedge clk);
      if (c >= 2 && c <= 5) chk("t1_scan", col[0], (c % 4 == 1) ? 4'hE : 4'hF);
      @(posedge clk); #1;
    end
    kp_row = 4'hF;
    wait_idle(0);

    // All keys on the clean-edge instance, every row pattern during hold
    for (int k = 0; k < 16; k++) begin
      kp_row = 4'hF; rk[1] = 4'(k); rv[1] = 1;
      @(posedge clk); #1; rv[1] = 0;
      @(negedge clk); #1;
      t = tab[k];
      for (int p = 0; p < 7; p++) begin
        kp_row = rpat[p];
        #1 chk($sformatf("t2_key%0h_row%0h", k, rpat[p]), col[1],
               (rpat[p] == t[7:4]) ? t[3:0] : 4'hF);
      end
      kp_row = 4'hF;
      wait_idle(1);
    end

    // Second request while busy is ignored; accepted once re-presented in IDLE
    kp_row = 4'b1101; rk[0] = 4'h8; rv[0] = 1;
    @(posedge clk); #1; rk[0] = 4'hA;
    repeat (3) @(negedge clk);
    chk("t3_hold_key8", col[0], 4'hE);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn[0]) break;
    end
    chk("t3_done", dn[0], 1);
    @(posedge clk); #1; rv[0] = 0;
    repeat (3) @(negedge clk);
    chk("t3_hold_keyA", col[0], 4'h7);
    wait_idle(0);

    // Cancel on the second hold cycle
    kp_row = 4'b1101; rk[0] = 4'h5; rv[0] = 1;
    @(posedge clk); #1; rv[0] = 0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!bsy[0]) break;
      cnt++;
      if (cnt == 4) begin chk("t4_hold", col[0], 4'hD); #1 cn[0] = 1; end
      if (cnt == 5) begin chk("t4_gap_col", col[0], 4'hF); #1 cn[0] = 0; end
    end
    chk("t4_busy_len", cnt, 6);
    chk("t4_done", dn[0], 1);
    @(posedge clk); #1;

    // Reset during hold of key 0
    kp_row = 4'b1110; rk[0] = 4'h0; rv[0] = 1;
    @(posedge clk); #1; rv[0] = 0;
    repeat (4) @(negedge clk);
    chk("t5_hold", col[0], 4'h7);
    #1 rs[0] = 0;
    @(negedge clk);
    chk("t5_col", col[0], 4'hF); chk("t5_busy", bsy[0], 0);
    chk("t5_ready", rdy[0], 0); chk("t5_done", dn[0], 0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_ready_low", rdy[0], 0); chk("t5_no_done", dn[0], 0);
    end
    #1 rs[0] = 1;
    #1 chk("t5_ready_back", rdy[0], 1);
    @(negedge clk);
    chk("t5_no_done_after", dn[0], 0);
    kp_row = 4'hF;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
